// File: rtl/window_addr_gen.sv
// Streams the linear address of every tap of a (2r+1)x(2r+1) window for each strided
// centre of a frame. Define BORDER_CLAMP_EN to add edge-replication clamping (border_mode).
module window_addr_gen #(
    parameter int ROW_W    = 11,
    parameter int COL_W    = 11,
    parameter int MAX_RAD  = 3,
    parameter int RAD_W    = 2,
    parameter int STRIDE_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROW_W-1:0]       row_max,
    input  logic [COL_W-1:0]       col_max,
    input  logic [RAD_W-1:0]       radius,
    input  logic [STRIDE_W-1:0]    stride,
`ifdef BORDER_CLAMP_EN
    input  logic                   border_mode,
`endif
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [ROW_W+COL_W-1:0] address,
    output logic                   addr_in_image,
    output logic                   win_first,
    output logic                   win_last,
    output logic [ROW_W-1:0]       center_row,
    output logic [COL_W-1:0]       center_col,
    output logic                   busy,
    output logic                   done
);
    localparam int AW  = ROW_W + COL_W;
    localparam int TRW = ROW_W + 2;
    localparam int TCW = COL_W + 2;
    localparam logic [RAD_W-1:0] MAX_RAD_V = RAD_W'(MAX_RAD);

    // state | meaning
    // IDLE  | waiting for start, config inputs are sampled here
    // RUN   | presenting taps, advancing on out_valid && out_ready
    // DONE  | one-cycle done pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      row_max_q, row_max_d;
    logic [COL_W-1:0]      col_max_q, col_max_d;
    logic [RAD_W-1:0]      rad_q, rad_d;
    logic [STRIDE_W-1:0]   stride_q, stride_d;
    logic [ROW_W-1:0]      crow_q, crow_d;
    logic [COL_W-1:0]      ccol_q, ccol_d;
    logic signed [RAD_W:0] dr_q, dr_d, dc_q, dc_d;
    logic [AW-1:0]         address_q, address_d;
    logic                  in_image_q, in_image_d;
    logic                  win_first_q, win_first_d;
    logic                  win_last_q, win_last_d;
`ifdef BORDER_CLAMP_EN
    logic                  border_q, border_d;
`endif

    logic                  load_tap;
    logic                  clamp_en;
    logic [RAD_W-1:0]      rad_sat;
    logic [STRIDE_W-1:0]   stride_eff;
    logic signed [RAD_W:0] rad_in_s, rad_s, rad_d_s;
    logic [COL_W:0]        ccol_next;
    logic [ROW_W:0]        crow_next;
    logic [TRW-1:0]        dr_ext;
    logic [TCW-1:0]        dc_ext;
    logic signed [TRW-1:0] tap_row;
    logic signed [TCW-1:0] tap_col;
    logic                  row_in, col_in;
    logic [ROW_W-1:0]      row_use;
    logic [COL_W-1:0]      col_use;
    logic [AW-1:0]         prod;

`ifdef BORDER_CLAMP_EN
    assign clamp_en = border_d;
`else
    assign clamp_en = 1'b0;
`endif

    always_comb begin
        rad_sat    = (radius > MAX_RAD_V) ? MAX_RAD_V : radius;
        stride_eff = (stride == '0) ? STRIDE_W'(1) : stride;
        rad_in_s   = $signed({1'b0, rad_sat});
        rad_s      = $signed({1'b0, rad_q});
        ccol_next  = {1'b0, ccol_q} + (COL_W+1)'(stride_q);
        crow_next  = {1'b0, crow_q} + (ROW_W+1)'(stride_q);
        state_d    = state_q;
        row_max_d  = row_max_q;
        col_max_d  = col_max_q;
        rad_d      = rad_q;
        stride_d   = stride_q;
        crow_d     = crow_q;
        ccol_d     = ccol_q;
        dr_d       = dr_q;
        dc_d       = dc_q;
`ifdef BORDER_CLAMP_EN
        border_d   = border_q;
`endif
        load_tap   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    row_max_d = row_max;
                    col_max_d = col_max;
                    rad_d     = rad_sat;
                    stride_d  = stride_eff;
`ifdef BORDER_CLAMP_EN
                    border_d  = border_mode;
`endif
                    crow_d    = '0;
                    ccol_d    = '0;
                    dr_d      = -rad_in_s;
                    dc_d      = -rad_in_s;
                    if (row_max == '0 || col_max == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RUN;
                        load_tap = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (dr_q != rad_s) begin
                        dr_d     = dr_q + (RAD_W+1)'(1);
                        load_tap = 1'b1;
                    end else begin
                        dr_d = -rad_s;
                        if (dc_q != rad_s) begin
                            dc_d     = dc_q + (RAD_W+1)'(1);
                            load_tap = 1'b1;
                        end else begin
                            dc_d = -rad_s;
                            if (ccol_next < {1'b0, col_max_q}) begin
                                ccol_d   = ccol_next[COL_W-1:0];
                                load_tap = 1'b1;
                            end else if (crow_next < {1'b0, row_max_q}) begin
                                ccol_d   = '0;
                                crow_d   = crow_next[ROW_W-1:0];
                                load_tap = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tap attributes are computed from the next coordinates so that address, flags
    // and centre all land in their registers on the same edge.
    always_comb begin
        dr_ext  = {{(TRW-RAD_W-1){dr_d[RAD_W]}}, dr_d};
        dc_ext  = {{(TCW-RAD_W-1){dc_d[RAD_W]}}, dc_d};
        tap_row = $signed({2'b00, crow_d}) + $signed(dr_ext);
        tap_col = $signed({2'b00, ccol_d}) + $signed(dc_ext);
        row_in  = !tap_row[TRW-1] && (tap_row < $signed({2'b00, row_max_d}));
        col_in  = !tap_col[TCW-1] && (tap_col < $signed({2'b00, col_max_d}));
        if (tap_row[TRW-1])  row_use = '0;
        else if (!row_in)    row_use = row_max_d - ROW_W'(1);
        else                 row_use = tap_row[ROW_W-1:0];
        if (tap_col[TCW-1])  col_use = '0;
        else if (!col_in)    col_use = col_max_d - COL_W'(1);
        else                 col_use = tap_col[COL_W-1:0];
        prod    = AW'(row_use) * AW'(col_max_d) + AW'(col_use);
        rad_d_s = $signed({1'b0, rad_d});
        address_d   = address_q;
        in_image_d  = in_image_q;
        win_first_d = win_first_q;
        win_last_d  = win_last_q;
        if (load_tap) begin
            in_image_d  = row_in && col_in;
            address_d   = ((row_in && col_in) || clamp_en) ? prod : '0;
            win_first_d = (dr_d == -rad_d_s) && (dc_d == -rad_d_s);
            win_last_d  = (dr_d == rad_d_s) && (dc_d == rad_d_s);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_max_q   <= '0;
            col_max_q   <= '0;
            rad_q       <= '0;
            stride_q    <= '0;
            crow_q      <= '0;
            ccol_q      <= '0;
            dr_q        <= '0;
            dc_q        <= '0;
            address_q   <= '0;
            in_image_q  <= 1'b0;
            win_first_q <= 1'b0;
            win_last_q  <= 1'b0;
`ifdef BORDER_CLAMP_EN
            border_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            row_max_q   <= row_max_d;
            col_max_q   <= col_max_d;
            rad_q       <= rad_d;
            stride_q    <= stride_d;
            crow_q      <= crow_d;
            ccol_q      <= ccol_d;
            dr_q        <= dr_d;
            dc_q        <= dc_d;
            address_q   <= address_d;
            in_image_q  <= in_image_d;
            win_first_q <= win_first_d;
            win_last_q  <= win_last_d;
`ifdef BORDER_CLAMP_EN
            border_q    <= border_d;
`endif
        end
    end

    assign out_valid     = (state_q == RUN);
    assign busy          = (state_q == RUN);
    assign done          = (state_q == DONE);
    assign address       = address_q;
    assign addr_in_image = in_image_q;
    assign win_first     = win_first_q;
    assign win_last      = win_last_q;
    assign center_row    = crow_q;
    assign center_col    = ccol_q;
endmodule
